cache_axi_arbiter: RTL and testbench

- Shares one AXI master port between the instruction cache (read-only) and the data cache (read and write-back).
- Converts each cache's rd_req/wr_req handshake into AXI AR/R and AW/W/B transactions.
- Arbitrates read requests and returns beats to the owning cache.
- Blocks reads that would overtake a pending write-back to the same line.
- Sits between the two cache instances and the SoC AXI interconnect.

---
 rtl/cache_axi_arbiter_pkg.sv | 45 ++++
 rtl/cache_axi_arbiter_if.sv | 92 +++++++++
 rtl/cache_axi_arbiter_axi_wr_channel.sv | 123 ++++++++++++
 rtl/cache_axi_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_axi_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types and constants for the cache-to-AXI arbiter: transfer types,
// AXI IDs, FSM state encodings and the type-to-AXI length/size mapping.
package cache_axi_arbiter_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_BEATS = 4;

    typedef enum logic [2:0] {
        T_BYTE = 3'd0,
        T_HALF = 3'd1,
        T_WORD = 3'd2,
        T_LINE = 3'd4
    } xfer_type_e;

    localparam logic [3:0] IC_ID = 4'd0;
    localparam logic [3:0] DC_ID = 4'd1;
    localparam logic [3:0] WR_ID = 4'd1;

    // Fixed AXI sideband values; the interconnect side ties these off.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_PROT       = 3'b000;
    localparam logic [3:0] AXI_CACHE      = 4'b0000;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_RESP
    } wr_state_e;

    function automatic logic [7:0] axi_len(input logic [2:0] typ, input int beats);
        return (typ == T_LINE) ? 8'(beats - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] axi_size(input logic [2:0] typ);
        return (typ == T_LINE) ? 3'd2 : {1'b0, typ[1:0]};
    endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// Bundle of cache-side request/return signals and the AXI master channels.
// master: the arbiter's view; slave: the caches + interconnect view.
interface cache_axi_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 4
);
    logic                     ic_rd_req;
    logic [2:0]               ic_rd_type;
    logic [ADDR_W-1:0]        ic_rd_addr;
    logic                     ic_rd_rdy;
    logic                     ic_ret_valid;
    logic                     ic_ret_last;
    logic [31:0]              ic_ret_data;

    logic                     dc_rd_req;
    logic [2:0]               dc_rd_type;
    logic [ADDR_W-1:0]        dc_rd_addr;
    logic                     dc_rd_rdy;
    logic                     dc_ret_valid;
    logic                     dc_ret_last;
    logic [31:0]              dc_ret_data;

    logic                     dc_wr_req;
    logic [2:0]               dc_wr_type;
    logic [ADDR_W-1:0]        dc_wr_addr;
    logic [3:0]               dc_wr_wstrb;
    logic [LINE_BEATS*32-1:0] dc_wr_data;
    logic                     dc_wr_rdy;

    logic [3:0]               arid;
    logic [ADDR_W-1:0]        araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic                     arvalid;
    logic                     arready;
    logic [3:0]               rid;
    logic [31:0]              rdata;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    logic [ADDR_W-1:0]        awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic                     awvalid;
    logic                     awready;
    logic [31:0]              wdata;
    logic [3:0]               wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;
    logic                     bvalid;
    logic                     bready;

    modport master (
        input  ic_rd_req, ic_rd_type, ic_rd_addr,
        output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        input  dc_rd_req, dc_rd_type, dc_rd_addr,
        output dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        input  dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
        output dc_wr_rdy,
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        output ic_rd_req, ic_rd_type, ic_rd_addr,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        output dc_rd_req, dc_rd_type, dc_rd_addr,
        input  dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        output dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
        input  dc_wr_rdy,
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_arbiter_axi_wr_channel.sv
// Write-back path: one dcache write at a time turned into an AXI AW/W/B burst.
// Also reports the line it is holding so the read side can block RAW overtakes.
module cache_axi_arbiter_axi_wr_channel
    import cache_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 4,
    parameter int LINE_OFF   = $clog2(LINE_BEATS * 4),
    parameter int BEAT_W     = $clog2(LINE_BEATS)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_req,
    input  logic [2:0]               wr_type,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [LINE_BEATS*32-1:0] wr_data,
    output logic                     wr_rdy,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready,
    output logic                     busy,
    output logic [ADDR_W-1:LINE_OFF] busy_line
);

    wr_state_e                w_state_reg;
    logic [ADDR_W-1:0]        addr_reg;
    logic [2:0]               type_reg;
    logic [3:0]               wstrb_reg;
    logic [LINE_BEATS*32-1:0] data_reg;
    logic [BEAT_W-1:0]        beat_reg;
    logic                     wr_rdy_reg;
    logic                     awvalid_reg;
    logic                     wvalid_reg;
    logic                     bready_reg;
    logic [31:0]              word [LINE_BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < LINE_BEATS; gi++) begin : g_word
            assign word[gi] = data_reg[gi*32 +: 32];
        end
    endgenerate

    assign wr_rdy    = wr_rdy_reg;
    assign awaddr    = addr_reg;
    assign awlen     = axi_len(type_reg, LINE_BEATS);
    assign awsize    = axi_size(type_reg);
    assign awvalid   = awvalid_reg;
    assign wvalid    = wvalid_reg;
    assign bready    = bready_reg;
    assign wdata     = word[beat_reg];
    // Line write-backs always carry whole words; partial strobes only for sub-line stores.
    assign wstrb     = (type_reg == T_LINE) ? 4'hF : wstrb_reg;
    assign wlast     = (beat_reg == awlen[BEAT_W-1:0]);
    assign busy      = (w_state_reg != W_IDLE);
    assign busy_line = addr_reg[ADDR_W-1:LINE_OFF];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_reg <= W_IDLE;
            addr_reg    <= '0;
            type_reg    <= '0;
            wstrb_reg   <= '0;
            data_reg    <= '0;
            beat_reg    <= '0;
            wr_rdy_reg  <= 1'b1;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (wr_req) begin
                        addr_reg    <= wr_addr;
                        type_reg    <= wr_type;
                        wstrb_reg   <= wr_wstrb;
                        data_reg    <= wr_data;
                        beat_reg    <= '0;
                        wr_rdy_reg  <= 1'b0;
                        awvalid_reg <= 1'b1;
                        w_state_reg <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid_reg <= 1'b0;
                        wvalid_reg  <= 1'b1;
                        w_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (wlast) begin
                            wvalid_reg  <= 1'b0;
                            bready_reg  <= 1'b1;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready_reg  <= 1'b0;
                        wr_rdy_reg  <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master between icache (reads) and dcache (reads + write-backs).
// Reads: fixed dcache priority, one outstanding burst, zero-latency beat return.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_BEATS = DEF_LINE_BEATS
) (
    input  logic                clk,
    input  logic                resetn,
    cache_axi_arbiter_if.master bus
);

    localparam int LINE_OFF = $clog2(LINE_BEATS * 4);

    rd_state_e                r_state_reg;
    logic [ADDR_W-1:0]        rd_addr_reg;
    logic [2:0]               rd_type_reg;
    logic [3:0]               rd_id_reg;
    logic                     arvalid_reg;
    logic                     rready_reg;

    logic                     gnt_dc;
    logic                     gnt_any;
    logic [ADDR_W-1:0]        gnt_addr;
    logic [2:0]               gnt_type;
    logic                     raw_hazard;
    logic                     grant_ok;
    logic                     beat_hit;
    logic                     wr_busy;
    logic [ADDR_W-1:LINE_OFF] wr_line;

    always_comb begin
        gnt_dc     = bus.dc_rd_req;
        gnt_any    = bus.dc_rd_req || bus.ic_rd_req;
        gnt_addr   = gnt_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
        gnt_type   = gnt_dc ? bus.dc_rd_type : bus.ic_rd_type;
        // A read of a line still being written back would return stale memory.
        raw_hazard = wr_busy && (gnt_addr[ADDR_W-1:LINE_OFF] == wr_line);
        grant_ok   = resetn && (r_state_reg == R_IDLE) && gnt_any && !raw_hazard;
        beat_hit   = (r_state_reg == R_DATA) && bus.rvalid && (bus.rid == rd_id_reg);
    end

    assign bus.dc_rd_rdy    = grant_ok && gnt_dc;
    assign bus.ic_rd_rdy    = grant_ok && !gnt_dc;

    assign bus.ic_ret_valid = beat_hit && (rd_id_reg == IC_ID);
    assign bus.ic_ret_last  = bus.ic_ret_valid && bus.rlast;
    assign bus.ic_ret_data  = bus.rdata;
    assign bus.dc_ret_valid = beat_hit && (rd_id_reg == DC_ID);
    assign bus.dc_ret_last  = bus.dc_ret_valid && bus.rlast;
    assign bus.dc_ret_data  = bus.rdata;

    assign bus.arid    = rd_id_reg;
    assign bus.araddr  = rd_addr_reg;
    assign bus.arlen   = axi_len(rd_type_reg, LINE_BEATS);
    assign bus.arsize  = axi_size(rd_type_reg);
    assign bus.arvalid = arvalid_reg;
    assign bus.rready  = rready_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_reg <= R_IDLE;
            rd_addr_reg <= '0;
            rd_type_reg <= '0;
            rd_id_reg   <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (grant_ok) begin
                        rd_addr_reg <= gnt_addr;
                        rd_type_reg <= gnt_type;
                        rd_id_reg   <= gnt_dc ? DC_ID : IC_ID;
                        arvalid_reg <= 1'b1;
                        r_state_reg <= R_AR;
                    end
                end
                R_AR: begin
                    if (bus.arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (beat_hit && bus.rlast) begin
                        rready_reg  <= 1'b0;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    cache_axi_arbiter_axi_wr_channel #(
        .ADDR_W     (ADDR_W),
        .LINE_BEATS (LINE_BEATS)
    ) u_wr (
        .clk       (clk),
        .resetn    (resetn),
        .wr_req    (bus.dc_wr_req),
        .wr_type   (bus.dc_wr_type),
        .wr_addr   (bus.dc_wr_addr),
        .wr_wstrb  (bus.dc_wr_wstrb),
        .wr_data   (bus.dc_wr_data),
        .wr_rdy    (bus.dc_wr_rdy),
        .awaddr    (bus.awaddr),
        .awlen     (bus.awlen),
        .awsize    (bus.awsize),
        .awvalid   (bus.awvalid),
        .awready   (bus.awready),
        .wdata     (bus.wdata),
        .wstrb     (bus.wstrb),
        .wlast     (bus.wlast),
        .wvalid    (bus.wvalid),
        .wready    (bus.wready),
        .bvalid    (bus.bvalid),
        .bready    (bus.bready),
        .busy      (wr_busy),
        .busy_line (wr_line)
    );

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed, table-driven bench for cache_axi_arbiter; the bench plays both the
// caches and a simple AXI slave. Tasks start and end just after a rising edge.
module tb_cache_axi_arbiter;
    import cache_axi_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cache_axi_arbiter_if bus ();

    cache_axi_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        dc;
        logic [2:0]  typ;
        logic [31:0] addr;
        int          delay;
        logic [31:0] base;
        logic        bad_rid;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
    } rd_vec_t;

    typedef struct {
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [127:0] data;
        int           delay;
        logic [7:0]   len;
        logic [2:0]   size;
        logic [3:0]   exp_wstrb;
    } wr_vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    rd_vec_t rd_tab [4];
    wr_vec_t wr_tab [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ic_rd_req = 0; bus.ic_rd_type = 0; bus.ic_rd_addr = 0;
        bus.dc_rd_req = 0; bus.dc_rd_type = 0; bus.dc_rd_addr = 0;
        bus.dc_wr_req = 0; bus.dc_wr_type = 0; bus.dc_wr_addr = 0;
        bus.dc_wr_wstrb = 0; bus.dc_wr_data = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
    endtask

    task automatic rd_issue(input rd_vec_t v);
        bit got = 0;
        if (v.dc) begin
            bus.dc_rd_req = 1; bus.dc_rd_type = v.typ; bus.dc_rd_addr = v.addr;
        end else begin
            bus.ic_rd_req = 1; bus.ic_rd_type = v.typ; bus.ic_rd_addr = v.addr;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((v.dc ? bus.dc_rd_rdy : bus.ic_rd_rdy) === 1'b1) begin
                got = 1;
                break;
            end
            tick();
        end
        check("rd_rdy_seen", 32'(got), 32'd1);
        tick();
        if (v.dc) bus.dc_rd_req = 0; else bus.ic_rd_req = 0;
    endtask

    task automatic rd_finish(input rd_vec_t v);
        @(negedge clk);
        check("arvalid", 32'(bus.arvalid), 32'd1);
        check("araddr", bus.araddr, v.addr);
        check("arlen", 32'(bus.arlen), 32'(v.len));
        check("arsize", 32'(bus.arsize), 32'(v.size));
        check("arid", 32'(bus.arid), 32'(v.id));
        repeat (v.delay) tick();
        @(negedge clk);
        check("araddr_held", bus.araddr, v.addr);
        bus.arready = 1;
        tick();
        bus.arready = 0;
        if (v.bad_rid) begin
            bus.rvalid = 1; bus.rid = ~v.id; bus.rdata = 32'hDEAD_BEEF; bus.rlast = 1;
            @(negedge clk);
            check("bad_rid_ic_ret", 32'(bus.ic_ret_valid), 32'd0);
            check("bad_rid_dc_ret", 32'(bus.dc_ret_valid), 32'd0);
            tick();
        end
        for (int i = 0; i <= int'(v.len); i++) begin
            bus.rvalid = 1; bus.rid = v.id; bus.rdata = v.base + 32'(i);
            bus.rlast = (i == int'(v.len));
            @(negedge clk);
            check("rready", 32'(bus.rready), 32'd1);
            check("own_ret_valid", 32'(v.dc ? bus.dc_ret_valid : bus.ic_ret_valid), 32'd1);
            check("own_ret_data", v.dc ? bus.dc_ret_data : bus.ic_ret_data, v.base + 32'(i));
            check("own_ret_last", 32'(v.dc ? bus.dc_ret_last : bus.ic_ret_last),
                  32'(i == int'(v.len)));
            check("other_ret_valid", 32'(v.dc ? bus.ic_ret_valid : bus.dc_ret_valid), 32'd0);
            tick();
        end
        bus.rvalid = 0; bus.rlast = 0;
    endtask

    task automatic wr_issue(input wr_vec_t v);
        bit got = 0;
        bus.dc_wr_req = 1; bus.dc_wr_type = v.typ; bus.dc_wr_addr = v.addr;
        bus.dc_wr_wstrb = v.wstrb; bus.dc_wr_data = v.data;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dc_wr_rdy === 1'b1) begin
                got = 1;
                break;
            end
            tick();
        end
        check("wr_rdy_seen", 32'(got), 32'd1);
        tick();
        bus.dc_wr_req = 0;
    endtask

    task automatic wr_finish(input wr_vec_t v);
        @(negedge clk);
        check("awvalid", 32'(bus.awvalid), 32'd1);
        check("awaddr", bus.awaddr, v.addr);
        check("awlen", 32'(bus.awlen), 32'(v.len));
        check("awsize", 32'(bus.awsize), 32'(v.size));
        check("wr_rdy_busy", 32'(bus.dc_wr_rdy), 32'd0);
        repeat (v.delay) tick();
        bus.awready = 1;
        tick();
        bus.awready = 0;
        // One stalled cycle first: the beat must not advance without wready.
        @(negedge clk);
        check("wvalid_stall", 32'(bus.wvalid), 32'd1);
        check("wdata_stall", bus.wdata, v.data[31:0]);
        tick();
        for (int i = 0; i <= int'(v.len); i++) begin
            bus.wready = 1;
            @(negedge clk);
            check("wvalid", 32'(bus.wvalid), 32'd1);
            check("wdata", bus.wdata, v.data[i*32 +: 32]);
            check("wstrb", 32'(bus.wstrb), 32'(v.exp_wstrb));
            check("wlast", 32'(bus.wlast), 32'(i == int'(v.len)));
            tick();
        end
        bus.wready = 0;
        @(negedge clk);
        check("bready", 32'(bus.bready), 32'd1);
        check("wr_rdy_resp", 32'(bus.dc_wr_rdy), 32'd0);
        bus.bvalid = 1;
        tick();
        bus.bvalid = 0;
    endtask

    rd_vec_t rv;
    rd_vec_t rv2;

    initial begin
        rd_tab[0] = '{1'b0, T_LINE, 32'h1C00_0040, 2, 32'h0000_000A, 1'b0, 8'd3, 3'd2, 4'd0};
        rd_tab[1] = '{1'b1, T_WORD, 32'h0000_1000, 0, 32'h0000_0100, 1'b1, 8'd0, 3'd2, 4'd1};
        rd_tab[2] = '{1'b1, T_BYTE, 32'h0000_5001, 1, 32'h0000_0055, 1'b0, 8'd0, 3'd0, 4'd1};
        rd_tab[3] = '{1'b0, T_HALF, 32'h0000_6002, 0, 32'h0000_0066, 1'b0, 8'd0, 3'd1, 4'd0};

        wr_tab[0] = '{T_LINE, 32'h0000_2000, 4'h0,
                      128'h000000D3_000000D2_000000D1_000000D0, 1, 8'd3, 3'd2, 4'hF};
        wr_tab[1] = '{T_BYTE, 32'h0000_0003, 4'b1000, 128'hEE00_0000, 0, 8'd0, 3'd0, 4'b1000};
        wr_tab[2] = '{T_HALF, 32'h0000_2006, 4'b1100, 128'hBEEF_0000, 2, 8'd0, 3'd1, 4'b1100};
        wr_tab[3] = '{T_WORD, 32'h0000_4000, 4'hF, 128'h1234_5678, 0, 8'd0, 3'd2, 4'hF};

        // Reset state, with both read requests asserted during reset.
        clear_inputs();
        bus.ic_rd_req = 1; bus.dc_rd_req = 1;
        tick(); tick();
        @(negedge clk);
        check("rst_ic_rd_rdy", 32'(bus.ic_rd_rdy), 32'd0);
        check("rst_dc_rd_rdy", 32'(bus.dc_rd_rdy), 32'd0);
        check("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("rst_wvalid", 32'(bus.wvalid), 32'd0);
        check("rst_rready", 32'(bus.rready), 32'd0);
        check("rst_bready", 32'(bus.bready), 32'd0);
        bus.ic_rd_req = 0; bus.dc_rd_req = 0;
        tick();
        resetn = 1;
        @(negedge clk);
        check("post_rst_wr_rdy", 32'(bus.dc_wr_rdy), 32'd1);
        tick();

        // Table-driven reads and writes.
        for (int t = 0; t < 4; t++) begin
            $display("read %0d: dc=%0d addr=0x%08h type=%0d", t, rd_tab[t].dc, rd_tab[t].addr, rd_tab[t].typ);
            rd_issue(rd_tab[t]);
            rd_finish(rd_tab[t]);
        end
        for (int t = 0; t < 4; t++) begin
            $display("write %0d: addr=0x%08h type=%0d", t, wr_tab[t].addr, wr_tab[t].typ);
            wr_issue(wr_tab[t]);
            wr_finish(wr_tab[t]);
            @(negedge clk);
            check("wr_rdy_after_b", 32'(bus.dc_wr_rdy), 32'd1);
            check("bready_after_b", 32'(bus.bready), 32'd0);
            tick();
        end

        // Simultaneous ic/dc requests: dcache first, icache right after dc's rlast.
        $display("seq: simultaneous ic/dc read requests");
        rv  = '{1'b1, T_WORD, 32'h0000_1000, 0, 32'h0000_0200, 1'b0, 8'd0, 3'd2, 4'd1};
        rv2 = '{1'b0, T_LINE, 32'h1C00_0080, 0, 32'h0000_0300, 1'b0, 8'd3, 3'd2, 4'd0};
        bus.ic_rd_req = 1; bus.ic_rd_type = T_LINE; bus.ic_rd_addr = rv2.addr;
        bus.dc_rd_req = 1; bus.dc_rd_type = T_WORD; bus.dc_rd_addr = rv.addr;
        @(negedge clk);
        check("sim_dc_rdy", 32'(bus.dc_rd_rdy), 32'd1);
        check("sim_ic_rdy", 32'(bus.ic_rd_rdy), 32'd0);
        tick();
        bus.dc_rd_req = 0;
        @(negedge clk);
        check("sim_ic_wait", 32'(bus.ic_rd_rdy), 32'd0);
        rd_finish(rv);
        @(negedge clk);
        check("sim_ic_granted", 32'(bus.ic_rd_rdy), 32'd1);
        tick();
        bus.ic_rd_req = 0;
        rd_finish(rv2);

        // RAW hazard: other-line read passes, same-line read waits for bvalid.
        $display("seq: read-after-write hazard");
        wr_issue(wr_tab[0]);
        rv = '{1'b1, T_WORD, 32'h0000_3000, 0, 32'h0000_0400, 1'b0, 8'd0, 3'd2, 4'd1};
        bus.dc_rd_req = 1; bus.dc_rd_type = T_WORD; bus.dc_rd_addr = rv.addr;
        @(negedge clk);
        check("raw_other_line_rdy", 32'(bus.dc_rd_rdy), 32'd1);
        tick();
        bus.dc_rd_req = 0;
        rd_finish(rv);
        rv = '{1'b1, T_WORD, 32'h0000_2008, 0, 32'h0000_0500, 1'b0, 8'd0, 3'd2, 4'd1};
        bus.dc_rd_req = 1; bus.dc_rd_type = T_WORD; bus.dc_rd_addr = rv.addr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("raw_same_line_blocked", 32'(bus.dc_rd_rdy), 32'd0);
            tick();
        end
        wr_finish(wr_tab[0]);
        @(negedge clk);
        check("raw_released_rdy", 32'(bus.dc_rd_rdy), 32'd1);
        check("raw_released_wr_rdy", 32'(bus.dc_wr_rdy), 32'd1);
        tick();
        bus.dc_rd_req = 0;
        rd_finish(rv);

        // Reset during the third beat of an icache line read, with a write stuck in AW.
        $display("seq: reset mid-burst");
        wr_issue(wr_tab[3]);
        rv = '{1'b0, T_LINE, 32'h1C00_0100, 0, 32'h0000_0600, 1'b0, 8'd3, 3'd2, 4'd0};
        rd_issue(rv);
        @(negedge clk);
        check("mid_awvalid_before", 32'(bus.awvalid), 32'd1);
        bus.arready = 1;
        tick();
        bus.arready = 0;
        for (int i = 0; i < 2; i++) begin
            bus.rvalid = 1; bus.rid = 4'd0; bus.rdata = rv.base + 32'(i); bus.rlast = 0;
            tick();
        end
        bus.rvalid = 1; bus.rdata = rv.base + 32'd2;
        resetn = 0;
        tick();
        bus.rvalid = 0;
        rv2 = '{1'b0, T_LINE, 32'h1C00_0200, 0, 32'h0000_0700, 1'b0, 8'd3, 3'd2, 4'd0};
        bus.ic_rd_req = 1; bus.ic_rd_type = T_LINE; bus.ic_rd_addr = rv2.addr;
        @(negedge clk);
        check("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("mid_rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("mid_rst_rready", 32'(bus.rready), 32'd0);
        check("mid_rst_ic_rdy", 32'(bus.ic_rd_rdy), 32'd0);
        tick();
        resetn = 1;
        @(negedge clk);
        check("mid_release_ic_rdy", 32'(bus.ic_rd_rdy), 32'd1);
        check("mid_release_wr_rdy", 32'(bus.dc_wr_rdy), 32'd1);
        tick();
        bus.ic_rd_req = 0;
        rd_finish(rv2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
